// File: rtl/jt12_sh_tap.sv
// Slot tap for time-multiplexed delay-line streams: tracks slot position, captures one slot on request.
// Optional macro JT12_SH_TAP_TIMEOUT_EN aborts a pending request after 2*stages stream advances.
module jt12_sh_tap #(
    parameter int   width  = 5,
    parameter int   stages = 32,
    parameter int   slot_w = 5,
    parameter logic rstval = 1'b0
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              clk_en,
    input  logic              zero,
    input  logic [width-1:0]  din,
    input  logic              rd_req,
    input  logic [slot_w-1:0] rd_slot,
    output logic              rd_ack,
    output logic [width-1:0]  rd_data,
    output logic              rd_err,
    output logic              rd_busy,
    output logic              locked,
    output logic              desync
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [slot_w-1:0] LAST_SLOT = slot_w'(stages - 1);
    localparam logic [slot_w:0]   NUM_SLOTS = (slot_w + 1)'(stages);

`ifdef JT12_SH_TAP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(2 * stages - 1);
    logic [7:0]        tmo_q, tmo_d;
`endif

    logic [0:0]        state_q, state_d;
    logic [slot_w-1:0] cnt_q, cnt_d;
    logic [slot_w-1:0] slot_q, slot_d;
    logic              locked_q, locked_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_err_q, rd_err_d;
    logic              desync_q, desync_d;
    logic [width-1:0]  rd_data_q, rd_data_d;

    logic [slot_w-1:0] cur_slot;
    logic              lock_ok;
    logic              hit;
    logic              slot_ok;

    always_comb begin
        cur_slot = zero ? '0 : cnt_q;
        lock_ok  = locked_q | zero;
        hit      = clk_en & lock_ok & (cur_slot == slot_q);
        slot_ok  = ({1'b0, rd_slot} < NUM_SLOTS);
    end

    // Stream-side tracking: a zero marker always re-anchors the counter.
    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        desync_d = 1'b0;
        if (clk_en) begin
            cnt_d = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
            if (zero) begin
                locked_d = 1'b1;
                desync_d = locked_q & (cnt_q != '0);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        rd_data_d = rd_data_q;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
`ifdef JT12_SH_TAP_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    if (slot_ok) begin
                        slot_d  = rd_slot;
                        state_d = ST_WAIT;
`ifdef JT12_SH_TAP_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        rd_ack_d = 1'b1;
                        rd_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    rd_data_d = din;
                    rd_ack_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
`ifdef JT12_SH_TAP_TIMEOUT_EN
                else if (clk_en) begin
                    if (tmo_q == TMO_LAST) begin
                        rd_ack_d = 1'b1;
                        rd_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            locked_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            desync_q  <= 1'b0;
            rd_data_q <= {width{rstval}};
`ifdef JT12_SH_TAP_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            locked_q  <= locked_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            desync_q  <= desync_d;
            rd_data_q <= rd_data_d;
`ifdef JT12_SH_TAP_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_err  = rd_err_q;
    assign rd_data = rd_data_q;
    assign rd_busy = (state_q == ST_WAIT);
    assign locked  = locked_q;
    assign desync  = desync_q;

endmodule
